sm_divider: RTL and testbench
=============================

Name: sm_divider

Overview:
Sequential sign-magnitude divider; the inverse of the team's combinational sign-magnitude multiplier.
- Accepts a product-format dividend (sign bit in the MSB, 4-bit magnitude) and a multiplier-format divisor (sign bit in the MSB, 2-bit magnitude).
- Uses restoring shift-subtract, one quotient bit per clock.
- Returns sign-magnitude quotient and remainder, plus zero and divide-by-zero flags.

Parameters:
- MAG_W, 4, dividend magnitude width; dividend port is MAG_W+1 bits.
- DIV_W, 2, divisor magnitude width; divisor port is DIV_W+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  MAG_W+1  [MAG_W] = sign, [MAG_W-1:0] = magnitude
- divisor  input  DIV_W+1  [DIV_W] = sign, [DIV_W-1:0] = magnitude
- busy  output  1  high from accept until done cycle, inclusive
- done  output  1  one-cycle pulse; results valid
- quotient  output  MAG_W+1  sign-magnitude quotient
- remainder  output  DIV_W+1  sign-magnitude remainder
- zero_flag  output  1  quotient magnitude == 0
- div_by_zero  output  1  divisor magnitude == 0 on last accepted request

Behaviour:
- Reset:
  - Asynchronous, active-low, applied immediately.
  - FSM goes to IDLE.
  - busy, done, quotient, remainder, zero_flag and div_by_zero all go to 0.
  - Reset mid-operation aborts the division; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch dividend and divisor and assert busy.
  - Divisor magnitude == 0: go to DONE.
  - Otherwise: load iteration counter = MAG_W, clear partial remainder (DIV_W+1 bits), go to RUN.
- RUN, each cycle:
  - Shift {partial remainder, dividend magnitude} left 1.
  - Trial-subtract the divisor magnitude from the partial remainder.
  - Non-negative result: keep it, quotient bit = 1. Negative result: restore, quotient bit = 0.
  - Decrement the counter; at 0, go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then return to IDLE.
  - Outputs are registered on entry to DONE and held stable until the next accepted start or reset.
- Latency (accept edge = edge where start is sampled in IDLE):
  - Normal division: done high in cycle accept+MAG_W+1.
  - Divide-by-zero: done high in cycle accept+1.
- Back-to-back: start in the DONE cycle is ignored. The next start is accepted in IDLE, one cycle after done.
- start while busy: ignored; latched operands are unaffected.
- Sign rules:
  - Quotient sign = dividend sign XOR divisor sign, forced to 0 when quotient magnitude is 0 (no negative zero).
  - Remainder sign = dividend sign, forced to 0 when remainder magnitude is 0.
  - Remainder magnitude < divisor magnitude, so it always fits in DIV_W bits.
- Divide-by-zero: quotient=0, remainder=0, zero_flag=1, div_by_zero=1.
- div_by_zero is cleared at the next normal result.
- Input dividend with magnitude 0 and sign 1 is treated as +0.

Optional Feature:
- Macro SM_DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if divisor magnitude != 0 and dividend magnitude < divisor magnitude:
  - Skip RUN and go straight to DONE; done is high at accept+1.
  - quotient=0, zero_flag=1, remainder = dividend magnitude with the dividend sign (0 if magnitude is 0).
- Not defined: all nonzero divisors take the full MAG_W iterations.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package sm_arith_pkg:
  - FSM state enum (IDLE/RUN/DONE).
  - Default MAG_W/DIV_W constants, shared with the multiplier.
  - Sign-bit index helpers.
- One natural sub-module, sm_div_step: purely combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once; the FSM and registers stay in sm_divider.

Test Plan:
- Dividend 0_1001 (+9), divisor 1_10 (-2), start for 1 cycle -> done at accept+5; quotient 1_0100 (-4), remainder 0_01 (+1), zero_flag=0, div_by_zero=0; busy high for 5 cycles.
- Dividend 1_0111 (-7), divisor 0_00 -> done at accept+1; quotient 0_0000, remainder 0_00, zero_flag=1, div_by_zero=1. Follow with 0_0110 / 0_11 -> quotient 0_0010, remainder 0_00, div_by_zero cleared.
- Dividend 1_0000 (-0), divisor 1_11 -> quotient 0_0000 (no negative zero), remainder 0_00, zero_flag=1. Dividend 1_1111, divisor 0_01 -> quotient 1_1111, remainder 0_00.
- Accept 0_1110 / 0_11; pulse start again at accept+2 with other operands -> ignored; done at accept+5 with quotient 0_0100, remainder 0_10; only one done pulse.
- Start a division, drop rst_n at accept+3 -> all outputs 0 immediately, no done. After release, 0_0101 / 0_10 completes normally: quotient 0_0010, remainder 0_01.
- Dividend 0_0010, divisor 0_11:
  - With SM_DIV_EARLY_EXIT_EN: done at accept+1.
  - Without it: done at accept+5.
  - Both: quotient 0_0000, remainder 0_10, zero_flag=1.

Source files
------------

// File: rtl/sm_arith_pkg.sv
// Shared sign-magnitude arithmetic definitions: FSM states, default widths
// (common with the multiplier) and sign-bit index helpers.
package sm_arith_pkg;

  localparam int DEF_MAG_W = 4;
  localparam int DEF_DIV_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sm_state_e;

  // In a sign-magnitude word of mag_w magnitude bits the sign sits just above them.
  function automatic int sign_bit(input int mag_w);
    return mag_w;
  endfunction

endpackage

// File: rtl/sm_divider_if.sv
// Request/result bundle for sm_divider. Valid/ready contract: start is a one-cycle
// request honoured only while busy=0; results are valid while done=1 and held after.
interface sm_divider_if
  import sm_arith_pkg::*;
#(
    parameter int MAG_W = DEF_MAG_W,
    parameter int DIV_W = DEF_DIV_W
) ();

    logic             start;
    logic [MAG_W:0]   dividend;
    logic [DIV_W:0]   divisor;
    logic             busy;
    logic             done;
    logic [MAG_W:0]   quotient;
    logic [DIV_W:0]   remainder;
    logic             zero_flag;
    logic             div_by_zero;
    sm_state_e        state_dbg;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, zero_flag, div_by_zero, state_dbg
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, zero_flag, div_by_zero, state_dbg
    );

endinterface

// File: rtl/sm_div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it does not go negative.
module sm_div_step #(
    parameter int DIV_W = 2
) (
    input  logic [DIV_W:0]   prem_i,
    input  logic             bit_i,
    input  logic [DIV_W-1:0] dvs_i,
    output logic [DIV_W:0]   prem_o,
    output logic             q_o
);

    logic [DIV_W+1:0] shifted;

    always_comb begin
        shifted = {prem_i, bit_i};
        q_o     = (shifted >= (DIV_W+2)'(dvs_i));
        prem_o  = q_o ? (DIV_W+1)'(shifted - (DIV_W+2)'(dvs_i)) : shifted[DIV_W:0];
    end

endmodule

// File: rtl/sm_divider.sv
// Sequential sign-magnitude restoring divider, one quotient bit per clock.
// Optional SM_DIV_EARLY_EXIT_EN: finish immediately when |dividend| < |divisor|.
module sm_divider
  import sm_arith_pkg::*;
#(
    parameter int MAG_W = DEF_MAG_W,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic          clk,
    input  logic          rst_n,
    sm_divider_if.slave   bus
);

    localparam int DVD_SB = sign_bit(MAG_W);
    localparam int DVS_SB = sign_bit(DIV_W);
    localparam int CNT_W  = $clog2(MAG_W + 1);

    sm_state_e        state_q, state_d;
    logic [MAG_W-1:0] dvd_mag_q, dvd_mag_d;
    logic             dvd_sign_q, dvd_sign_d;
    logic [DIV_W-1:0] dvs_mag_q, dvs_mag_d;
    logic             dvs_sign_q, dvs_sign_d;
    logic [DIV_W:0]   prem_q, prem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAG_W:0]   quotient_q, quotient_d;
    logic [DIV_W:0]   remainder_q, remainder_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic [DIV_W:0]   step_prem;
    logic             step_q;
    logic [MAG_W-1:0] q_mag;
    logic [DIV_W-1:0] r_mag;

    sm_div_step #(.DIV_W(DIV_W)) u_step (
        .prem_i (prem_q),
        .bit_i  (dvd_mag_q[MAG_W-1]),
        .dvs_i  (dvs_mag_q),
        .prem_o (step_prem),
        .q_o    (step_q)
    );

    always_comb begin
        state_d     = state_q;
        dvd_mag_d   = dvd_mag_q;
        dvd_sign_d  = dvd_sign_q;
        dvs_mag_d   = dvs_mag_q;
        dvs_sign_d  = dvs_sign_q;
        prem_d      = prem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        q_mag       = {dvd_mag_q[MAG_W-2:0], step_q};
        r_mag       = step_prem[DIV_W-1:0];

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dvd_sign_d = bus.dividend[DVD_SB];
                    dvd_mag_d  = bus.dividend[MAG_W-1:0];
                    dvs_sign_d = bus.divisor[DVS_SB];
                    dvs_mag_d  = bus.divisor[DIV_W-1:0];
                    if (bus.divisor[DIV_W-1:0] == '0) begin
                        quotient_d  = '0;
                        remainder_d = '0;
                        zero_d      = 1'b1;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end
`ifdef SM_DIV_EARLY_EXIT_EN
                    else if (bus.dividend[MAG_W-1:0] < MAG_W'(bus.divisor[DIV_W-1:0])) begin
                        // Quotient is 0 and the dividend itself is the remainder (fits DIV_W bits).
                        quotient_d  = '0;
                        remainder_d = {bus.dividend[DVD_SB] & (|bus.dividend[DIV_W-1:0]),
                                       bus.dividend[DIV_W-1:0]};
                        zero_d      = 1'b1;
                        dbz_d       = 1'b0;
                        state_d     = ST_DONE;
                    end
`endif
                    else begin
                        cnt_d   = CNT_W'(MAG_W);
                        prem_d  = '0;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // Quotient bits shift into the vacated low end of the dividend register.
                prem_d    = step_prem;
                dvd_mag_d = q_mag;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = {(dvd_sign_q ^ dvs_sign_q) & (|q_mag), q_mag};
                    remainder_d = {dvd_sign_q & (|r_mag), r_mag};
                    zero_d      = ~(|q_mag);
                    dbz_d       = 1'b0;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dvd_mag_q   <= '0;
            dvd_sign_q  <= 1'b0;
            dvs_mag_q   <= '0;
            dvs_sign_q  <= 1'b0;
            prem_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_mag_q   <= dvd_mag_d;
            dvd_sign_q  <= dvd_sign_d;
            dvs_mag_q   <= dvs_mag_d;
            dvs_sign_q  <= dvs_sign_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.zero_flag   = zero_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_sm_divider.sv
// Self-checking bench for sm_divider: directed cases plus random operands
// scored against an arithmetic (/ and %) reference model.
module tb_sm_divider;
    import sm_arith_pkg::*;

    localparam int MAG_W = 4;
    localparam int DIV_W = 2;
    localparam int RES_W = (MAG_W + 1) + (DIV_W + 1) + 2;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic [RES_W-1:0] exp_q[$];

    sm_divider_if #(.MAG_W(MAG_W), .DIV_W(DIV_W)) bus ();

    sm_divider #(.MAG_W(MAG_W), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division on magnitudes, sign rules applied afterwards.
    function automatic logic [RES_W-1:0] model(input logic [MAG_W:0] dvd, input logic [DIV_W:0] dvs);
        int dm, ds, qm, rm;
        logic qs, rs, z, dbz;
        dm = int'(dvd[MAG_W-1:0]);
        ds = int'(dvs[DIV_W-1:0]);
        if (ds == 0) begin
            qm = 0; rm = 0; qs = 1'b0; rs = 1'b0; z = 1'b1; dbz = 1'b1;
        end else begin
            qm  = dm / ds;
            rm  = dm % ds;
            qs  = (dvd[MAG_W] ^ dvs[DIV_W]) && (qm != 0);
            rs  = dvd[MAG_W] && (rm != 0);
            z   = (qm == 0);
            dbz = 1'b0;
        end
        return {qs, MAG_W'(qm), rs, DIV_W'(rm), z, dbz};
    endfunction

    function automatic int model_latency(input logic [MAG_W:0] dvd, input logic [DIV_W:0] dvs);
        if (dvs[DIV_W-1:0] == '0) return 1;
`ifdef SM_DIV_EARLY_EXIT_EN
        if (int'(dvd[MAG_W-1:0]) < int'(dvs[DIV_W-1:0])) return 1;
`endif
        return MAG_W + 1;
    endfunction

    // ---------------- driver ----------------
    // glitch_cyc > 0 raises start with junk operands in that cycle after accept.
    task automatic run_div(input logic [MAG_W:0] dvd, input logic [DIV_W:0] dvs, input int glitch_cyc);
        int k, busy_cnt, lat;
        bit seen;
        logic [RES_W-1:0] exp;
        logic [MAG_W:0] q_hold;
        exp_q.push_back(model(dvd, dvs));
        lat = model_latency(dvd, dvs);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        k = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (k == glitch_cyc) begin
                bus.start    = 1'b1;
                bus.dividend = (MAG_W+1)'($urandom_range(0, 31));
                bus.divisor  = (DIV_W+1)'($urandom_range(0, 7));
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) seen = 1'b1;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("latency", k, lat);
        check_eq("busy_cycles", busy_cnt, lat);
        exp = exp_q.pop_front();
        check_eq("quotient", 32'(bus.quotient), 32'(exp[RES_W-1 -: MAG_W+1]));
        check_eq("remainder", 32'(bus.remainder), 32'(exp[DIV_W+2 -: DIV_W+1]));
        check_eq("zero_flag", 32'(bus.zero_flag), 32'(exp[1]));
        check_eq("div_by_zero", 32'(bus.div_by_zero), 32'(exp[0]));
        q_hold = bus.quotient;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("post_done", {30'd0, bus.done, bus.busy}, 32'd0);
        check_eq("quotient_held", 32'(bus.quotient), 32'(q_hold));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {bus.busy, bus.done, bus.zero_flag, bus.div_by_zero,
                       20'd0, bus.remainder, bus.quotient}, 32'd0);
        check_eq({tag, "_state"}, 32'(bus.state_dbg), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_div(5'b0_1001, 3'b1_10, 0);   // +9 / -2
        run_div(5'b1_0111, 3'b0_00, 0);   // divide by zero
        run_div(5'b0_0110, 3'b0_11, 0);   // clears div_by_zero
        run_div(5'b1_0000, 3'b1_11, 0);   // -0 dividend
        run_div(5'b1_1111, 3'b0_01, 0);
        run_div(5'b0_0010, 3'b0_11, 0);   // dividend smaller than divisor
        run_div(5'b0_1110, 3'b0_11, 2);   // start while busy is ignored

        // Abort mid-division with reset; no done may appear.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 5'b0_1011;
        bus.divisor  = 3'b0_01;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_div(5'b0_0101, 3'b0_10, 0);

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            run_div((MAG_W+1)'($urandom_range(0, 31)), (DIV_W+1)'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
